// File: rtl/nor_bist_if.sv
// nor_bist_if: operand/result and status bundle between nor_bist and its unit under test.
interface nor_bist_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    modport master (input start, result, output a, b, busy, done, pass, err_count, fail_a, fail_b);
    modport slave (output start, result, input a, b, busy, done, pass, err_count, fail_a, fail_b);
endinterface

// File: rtl/nor_bist.sv
// nor_bist: exhaustive NOR checker for a WIDTH-bit logic unit; define NOR_BIST_FIRST_FAIL_EN
// to build registers that capture the first mismatching operand pair.
module nor_bist #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1
) (
    input logic        clk,
    input logic        rst_n,
    nor_bist_if.master bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     cnt_q, cnt_d;
    logic [2:0]             wt_q, wt_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
    logic [15:0]            err_q, err_d;
    logic                   go, mis, done;
    assign go   = (state_q == IDLE || state_q == DONE) && bus.start;
    assign mis  = bus.result != ~(a_q | b_q);
    assign done = state_q == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wt_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wt_q    <= wt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wt_d    = wt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: if (go) begin
                state_d = DRIVE;
                cnt_d   = '0;
                err_d   = '0;
            end
            DRIVE: begin
                {a_d, b_d} = cnt_q;
                wt_d       = '0;
                state_d    = (LAT == 0) ? CHECK : WAIT;
            end
            WAIT: begin
                wt_d    = wt_q + 3'd1;
                state_d = (wt_q == 3'(LAT - 1)) ? CHECK : WAIT;
            end
            CHECK: begin
                err_d   = (mis && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
                cnt_d   = cnt_q + (2*WIDTH)'(1);
                state_d = (&cnt_q) ? DONE : DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = state_q == DRIVE || state_q == WAIT || state_q == CHECK;
    assign bus.done      = done;
    assign bus.pass      = done && err_q == '0;
    assign bus.err_count = err_q;
`ifdef NOR_BIST_FIRST_FAIL_EN
    logic [WIDTH-1:0] fa_q, fb_q;
    // err_q never returns to zero within a run, so zero marks the first mismatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_q <= '0;
            fb_q <= '0;
        end else if (go) begin
            fa_q <= '0;
            fb_q <= '0;
        end else if (state_q == CHECK && mis && err_q == '0) begin
            fa_q <= a_q;
            fb_q <= b_q;
        end
    end
    assign bus.fail_a = fa_q;
    assign bus.fail_b = fb_q;
`else
    assign bus.fail_a = '0;
    assign bus.fail_b = '0;
`endif
endmodule
